// File: rtl/evt_packet_decoder.sv
// evt_packet_decoder
//
// Takes address-event packets from the arbiter through a small FIFO, splits
// each one into timestamp / row / column / polarity and hierarchical address
// fields, and presents the result on a valid/ready output register.
// Alongside decoding it keeps saturating polarity and ordering-error counters,
// a 64-bit map of the pixels seen in the current frame, and a timestamp
// ordering check against the previous decoded event.
//
// Ports
//   clk         rising-edge clock for all logic
//   reset       synchronous, active-low reset
//   in_valid    packet offered by the arbiter
//   in_data     packet {ts, row, col, pol}
//   in_ready    FIFO has room (from registered occupancy only)
//   out_valid   decoded event present on out_*
//   out_ready   consumer accepts the decoded event
//   out_ts      timestamp
//   out_row     full row address
//   out_col     full column address
//   out_pol     polarity, 1 = positive
//   out_group   {row[2], col[2]} higher-level group
//   out_lrow    row[1:0] level-0 row
//   out_lcol    col[1:0] level-0 column
//   out_ts_err  this event is older than the previous one
//   pos_cnt     saturating count of positive events
//   neg_cnt     saturating count of negative events
//   err_cnt     saturating count of ordering errors
//   active_map  one bit per pixel, index row*8+col
//   frame_clr   one-cycle pulse clearing active_map and ordering history

module evt_packet_decoder #(
    parameter int WIDTH      = 39,
    parameter int SIZE       = 32,
    parameter int ROW_ADD    = 3,
    parameter int COL_ADD    = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SIZE-1:0]    out_ts,
    output logic [ROW_ADD-1:0] out_row,
    output logic [COL_ADD-1:0] out_col,
    output logic               out_pol,
    output logic [1:0]         out_group,
    output logic [1:0]         out_lrow,
    output logic [1:0]         out_lcol,
    output logic               out_ts_err,
    output logic [CNT_W-1:0]   pos_cnt,
    output logic [CNT_W-1:0]   neg_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [63:0]        active_map,
    input  logic               frame_clr
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]      DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]      OCC_ONE = 1;
    localparam logic [AW-1:0]    PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        EMPTY,
        HOLD
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;

    logic             push;
    logic             decode;
    logic             fifo_empty;

    logic [WIDTH-1:0]   head;
    logic [SIZE-1:0]    head_ts;
    logic [ROW_ADD-1:0] head_row;
    logic [COL_ADD-1:0] head_col;
    logic               head_pol;
    logic [5:0]         map_idx;
    logic [63:0]        map_bit;

    logic [SIZE-1:0]    last_ts;
    logic               has_prior;
    logic               ts_bad;

    // in_ready comes only from the registered occupancy, so a pop in the
    // same cycle never opens the door for a push (no bypass path).
    assign fifo_empty = (occ == '0);
    assign in_ready   = (occ < DEPTH_C);
    assign push       = in_valid && in_ready;
    assign out_valid  = (state == HOLD);
    assign decode     = !fifo_empty && (!out_valid || out_ready);

    assign head     = mem[rd_ptr];
    assign head_ts  = head[WIDTH-1 -: SIZE];
    assign head_row = head[ROW_ADD+COL_ADD : COL_ADD+1];
    assign head_col = head[COL_ADD:1];
    assign head_pol = head[0];
    assign map_idx  = {head_row[2:0], head_col[2:0]};
    assign map_bit  = 64'd1 << map_idx;

    // A frame clear in the decode cycle wipes history first, so the new
    // event is never compared against the previous frame.
    assign ts_bad = has_prior && !frame_clr && (head_ts < last_ts);

    // FIFO storage; entries need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; a push and a pop together leave the
    // occupancy unchanged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (decode) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, decode})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

    // Output control state register: HOLD is exactly out_valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: stay in HOLD while events keep arriving so a
    // ready consumer sees one event per cycle.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (decode) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = fifo_empty ? EMPTY : HOLD;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Decode register, ordering history, counters and pixel map. Output
    // fields only change on decode, which keeps them stable under
    // backpressure. When frame_clr and decode coincide the map is rebuilt
    // holding only the new event's bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_ts     <= '0;
            out_row    <= '0;
            out_col    <= '0;
            out_pol    <= 1'b0;
            out_group  <= '0;
            out_lrow   <= '0;
            out_lcol   <= '0;
            out_ts_err <= 1'b0;
            pos_cnt    <= '0;
            neg_cnt    <= '0;
            err_cnt    <= '0;
            active_map <= '0;
            last_ts    <= '0;
            has_prior  <= 1'b0;
        end else begin
            if (decode) begin
                out_ts     <= head_ts;
                out_row    <= head_row;
                out_col    <= head_col;
                out_pol    <= head_pol;
                out_group  <= {head_row[ROW_ADD-1], head_col[COL_ADD-1]};
                out_lrow   <= head_row[1:0];
                out_lcol   <= head_col[1:0];
                out_ts_err <= ts_bad;
                last_ts    <= head_ts;
                has_prior  <= 1'b1;
                if (ts_bad && (err_cnt != CNT_MAX)) begin
                    err_cnt <= err_cnt + CNT_ONE;
                end
                if (head_pol) begin
                    if (pos_cnt != CNT_MAX) begin
                        pos_cnt <= pos_cnt + CNT_ONE;
                    end
                end else begin
                    if (neg_cnt != CNT_MAX) begin
                        neg_cnt <= neg_cnt + CNT_ONE;
                    end
                end
            end else if (frame_clr) begin
                has_prior <= 1'b0;
            end

            if (frame_clr && decode) begin
                active_map <= map_bit;
            end else if (frame_clr) begin
                active_map <= '0;
            end else if (decode) begin
                active_map <= active_map | map_bit;
            end
        end
    end

endmodule

// File: tb/tb_evt_packet_decoder.sv
// tb_evt_packet_decoder
//
// Directed self-checking bench for evt_packet_decoder. Each scenario task
// drives its own stimulus and compares outputs against hand-computed values.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.

module tb_evt_packet_decoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [38:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ts;
    logic [2:0]  out_row;
    logic [2:0]  out_col;
    logic        out_pol;
    logic [1:0]  out_group;
    logic [1:0]  out_lrow;
    logic [1:0]  out_lcol;
    logic        out_ts_err;
    logic [15:0] pos_cnt;
    logic [15:0] neg_cnt;
    logic [15:0] err_cnt;
    logic [63:0] active_map;
    logic        frame_clr;

    int checks = 0;
    int errors = 0;

    int          exp_pos = 0;
    int          exp_neg = 0;
    int          exp_err = 0;
    logic [63:0] exp_map = '0;

    evt_packet_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ts     (out_ts),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_pol    (out_pol),
        .out_group  (out_group),
        .out_lrow   (out_lrow),
        .out_lcol   (out_lcol),
        .out_ts_err (out_ts_err),
        .pos_cnt    (pos_cnt),
        .neg_cnt    (neg_cnt),
        .err_cnt    (err_cnt),
        .active_map (active_map),
        .frame_clr  (frame_clr)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge, then settle 1 ns before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [38:0] mk(input logic [31:0] ts, input logic [2:0] r,
                                       input logic [2:0] c, input logic p);
        return {ts, r, c, p};
    endfunction

    function automatic logic [63:0] bit_of(input int r, input int c);
        logic [63:0] one;
        one = 64'd1;
        return one << (r * 8 + c);
    endfunction

    // Push one packet into an empty decoder and wait the two edges it needs
    // to reach the output register; out_ready is left low.
    task automatic send_one(input logic [38:0] pkt);
        in_data  = pkt;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        frame_clr = 1'b0;
        step();
        step();
        reset   = 1'b1;
        exp_pos = 0;
        exp_neg = 0;
        exp_err = 0;
        exp_map = '0;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        in_data   = '0;
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0b exp 1", in_ready); end
        checks++; if (out_ts !== 32'd0 || out_row !== 3'd0 || out_col !== 3'd0 || out_group !== 2'd0)
            begin errors++; $display("[TB] FAIL reset_fields got ts=%0h row=%0d col=%0d grp=%0d exp 0", out_ts, out_row, out_col, out_group); end
        checks++; if (pos_cnt !== 16'd0 || neg_cnt !== 16'd0 || err_cnt !== 16'd0)
            begin errors++; $display("[TB] FAIL reset_counters got %0d/%0d/%0d exp 0/0/0", pos_cnt, neg_cnt, err_cnt); end
        checks++; if (active_map !== 64'd0 || out_ts_err !== 1'b0)
            begin errors++; $display("[TB] FAIL reset_map got map=%0h err=%0b exp 0/0", active_map, out_ts_err); end
    endtask

    task automatic test_single();
        in_data   = mk(32'h0000_0010, 3'd5, 3'd6, 1'b1);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid got %0b exp 0", out_valid); end
        step();
        exp_pos++;
        exp_map |= bit_of(5, 6);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %0b exp 1", out_valid); end
        checks++; if (out_ts !== 32'h10 || out_row !== 3'd5 || out_col !== 3'd6 || out_pol !== 1'b1)
            begin errors++; $display("[TB] FAIL single_fields got ts=%0h row=%0d col=%0d pol=%0b exp 10/5/6/1", out_ts, out_row, out_col, out_pol); end
        checks++; if (out_group !== 2'd3 || out_lrow !== 2'd1 || out_lcol !== 2'd2)
            begin errors++; $display("[TB] FAIL single_hier got grp=%0d lrow=%0d lcol=%0d exp 3/1/2", out_group, out_lrow, out_lcol); end
        checks++; if (pos_cnt !== 16'(exp_pos) || active_map[46] !== 1'b1 || active_map !== exp_map)
            begin errors++; $display("[TB] FAIL single_cnt_map got pos=%0d map=%0h exp %0d/%0h", pos_cnt, active_map, exp_pos, exp_map); end
        consume();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_clear_valid got %0b exp 0", out_valid); end
    endtask

    // One event stalls in the output register, the FIFO then fills with
    // four more, a fifth is refused; release drains them back-to-back.
    task automatic test_back_to_back();
        logic [31:0] bts [6];
        int          br  [6];
        int          bc  [6];
        logic        bp  [6];
        int          accepted;
        bts = '{32'd200, 32'd210, 32'd220, 32'd230, 32'd240, 32'd250};
        br  = '{0, 2, 3, 7, 4, 6};
        bc  = '{1, 2, 7, 0, 4, 6};
        bp  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        accepted = 0;
        send_one(mk(bts[0], 3'(br[0]), 3'(bc[0]), bp[0]));
        for (int i = 1; i <= 5; i++) begin
            in_data  = mk(bts[i], 3'(br[i]), 3'(bc[i]), bp[i]);
            in_valid = 1'b1;
            if (in_ready === 1'b1) begin
                step();
                accepted++;
            end
        end
        checks++; if (accepted != 4) begin errors++; $display("[TB] FAIL bp_accepted got %0d exp 4", accepted); end
        for (int k = 0; k < 3; k++) step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready got %0b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_ts !== bts[0] || out_col !== 3'd1)
            begin errors++; $display("[TB] FAIL bp_stable got v=%0b ts=%0d col=%0d exp 1/200/1", out_valid, out_ts, out_col); end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bp[i]) exp_pos++; else exp_neg++;
            exp_map |= bit_of(br[i], bc[i]);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++; if (out_valid !== 1'b1 || out_ts !== bts[i] || out_row !== 3'(br[i]) || out_col !== 3'(bc[i]))
                begin errors++; $display("[TB] FAIL drain_%0d got v=%0b ts=%0d row=%0d col=%0d exp 1/%0d/%0d/%0d", i, out_valid, out_ts, out_row, out_col, bts[i], br[i], bc[i]); end
            if (i == 2) begin
                checks++; if (out_group !== 2'd1 || out_lrow !== 2'd3 || out_lcol !== 2'd3)
                    begin errors++; $display("[TB] FAIL drain_hier got grp=%0d lrow=%0d lcol=%0d exp 1/3/3", out_group, out_lrow, out_lcol); end
            end
        end
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_end_valid got %0b exp 0", out_valid); end
        checks++; if (pos_cnt !== 16'(exp_pos) || neg_cnt !== 16'(exp_neg))
            begin errors++; $display("[TB] FAIL drain_counts got %0d/%0d exp %0d/%0d", pos_cnt, neg_cnt, exp_pos, exp_neg); end
        checks++; if (active_map !== exp_map) begin errors++; $display("[TB] FAIL drain_map got %0h exp %0h", active_map, exp_map); end
    endtask

    task automatic test_ts_order();
        logic [31:0] tsv [4];
        logic        expe [4];
        tsv  = '{32'd100, 32'd100, 32'd90, 32'd120};
        expe = '{1'b0, 1'b0, 1'b1, 1'b0};
        frame_clr = 1'b1;
        step();
        frame_clr = 1'b0;
        exp_map = '0;
        checks++; if (active_map !== 64'd0) begin errors++; $display("[TB] FAIL fclr_map got %0h exp 0", active_map); end
        for (int i = 0; i < 4; i++) begin
            send_one(mk(tsv[i], 3'd1, 3'(i), 1'b0));
            exp_neg++;
            if (expe[i]) exp_err++;
            checks++; if (out_valid !== 1'b1 || out_ts_err !== expe[i])
                begin errors++; $display("[TB] FAIL ts_err_%0d got v=%0b err=%0b exp 1/%0b", i, out_valid, out_ts_err, expe[i]); end
            consume();
        end
        checks++; if (err_cnt !== 16'(exp_err) || neg_cnt !== 16'(exp_neg))
            begin errors++; $display("[TB] FAIL ts_err_cnt got %0d neg=%0d exp %0d/%0d", err_cnt, neg_cnt, exp_err, exp_neg); end
    endtask

    task automatic test_frame_clr_coincident();
        frame_clr = 1'b1;
        step();
        frame_clr = 1'b0;
        send_one(mk(32'd50, 3'd2, 3'd3, 1'b1));
        exp_pos++;
        checks++; if (out_ts_err !== 1'b0 || active_map !== bit_of(2, 3))
            begin errors++; $display("[TB] FAIL fc_first got err=%0b map=%0h exp 0/%0h", out_ts_err, active_map, bit_of(2, 3)); end
        consume();
        in_data  = mk(32'd5, 3'd0, 3'd0, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid  = 1'b0;
        frame_clr = 1'b1;
        step();
        frame_clr = 1'b0;
        exp_pos++;
        checks++; if (out_valid !== 1'b1 || active_map !== 64'h1 || out_ts_err !== 1'b0 || out_ts !== 32'd5)
            begin errors++; $display("[TB] FAIL fc_coincident got v=%0b map=%0h err=%0b ts=%0d exp 1/1/0/5", out_valid, active_map, out_ts_err, out_ts); end
        checks++; if (err_cnt !== 16'(exp_err)) begin errors++; $display("[TB] FAIL fc_err_cnt got %0d exp %0d", err_cnt, exp_err); end
        consume();
        send_one(mk(32'd4, 3'd1, 3'd0, 1'b0));
        exp_neg++;
        exp_err++;
        checks++; if (out_ts_err !== 1'b1 || err_cnt !== 16'(exp_err) || active_map !== 64'h101)
            begin errors++; $display("[TB] FAIL fc_history got err=%0b cnt=%0d map=%0h exp 1/%0d/101", out_ts_err, err_cnt, active_map, exp_err); end
        consume();
    endtask

    task automatic test_saturation();
        int sent;
        do_reset();
        sent      = 0;
        out_ready = 1'b1;
        in_data   = mk(32'd7, 3'd3, 3'd3, 1'b1);
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 70000 && sent < 65535; cyc++) begin
            if (in_ready === 1'b1) sent++;
            step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        out_ready = 1'b0;
        checks++; if (sent != 65535) begin errors++; $display("[TB] FAIL sat_stream got %0d sent exp 65535", sent); end
        checks++; if (pos_cnt !== 16'hFFFF || err_cnt !== 16'd0)
            begin errors++; $display("[TB] FAIL sat_preload got pos=%0h err=%0d exp FFFF/0", pos_cnt, err_cnt); end
        send_one(mk(32'd8, 3'd3, 3'd4, 1'b1));
        consume();
        checks++; if (pos_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_hold got %0h exp FFFF", pos_cnt); end
        send_one(mk(32'd9, 3'd3, 3'd5, 1'b0));
        consume();
        checks++; if (neg_cnt !== 16'd1) begin errors++; $display("[TB] FAIL sat_neg got %0d exp 1", neg_cnt); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data  = mk(32'(300 + i), 3'(i), 3'(i), 1'b1);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_ts !== 32'd300)
            begin errors++; $display("[TB] FAIL mid_loaded got v=%0b ts=%0d exp 1/300", out_valid, out_ts); end
        do_reset();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("[TB] FAIL mid_reset got v=%0b rdy=%0b exp 0/1", out_valid, in_ready); end
        checks++; if (pos_cnt !== 16'd0 || neg_cnt !== 16'd0 || err_cnt !== 16'd0 || active_map !== 64'd0)
            begin errors++; $display("[TB] FAIL mid_counters got %0d/%0d/%0d map=%0h exp 0", pos_cnt, neg_cnt, err_cnt, active_map); end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_stale_%0d got %0b exp 0", k, out_valid); end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        frame_clr = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_ts_order();
        test_frame_clr_coincident();
        test_saturation();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/evt_packet_decoder.md
EVT_PACKET_DECODER -- requirements
Module: evt_packet_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 39, meaning the event packet width (timestamp + row addr + col addr + polarity).
REQ-002 SHALL have parameter SIZE, default 32, meaning the timestamp width.
REQ-003 SHALL have parameters ROW_ADD and COL_ADD, default 3 each, meaning the address widths (1 higher-level bit + 2 level-0 bits).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning the input buffer depth, power of 2.
REQ-005 SHALL have parameter CNT_W, default 16, meaning the width of the polarity and error counters.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port in_valid, input, 1 bit, and port in_data, input, WIDTH bits: the event packet from the arbiter.
REQ-009 SHALL have port in_ready, output, 1 bit: high when the decoder can accept a packet.
REQ-010 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the decoded-event handshake.
REQ-011 SHALL have outputs out_ts (SIZE), out_row (ROW_ADD), out_col (COL_ADD), out_pol (1), out_group (2, {row[2],col[2]}), out_lrow (2) and out_lcol (2): the decoded event fields.
REQ-012 SHALL have output out_ts_err, 1 bit: marks that the current output event broke timestamp ordering.
REQ-013 SHALL have outputs pos_cnt, neg_cnt and err_cnt, each CNT_W bits, and output active_map, 64 bits (bit index row*8+col).
REQ-014 SHALL have input frame_clr, 1 bit: a single-cycle pulse that clears active_map and timestamp-check history.

Function
REQ-015 SHALL use this packet format: in_data[38:7] is the timestamp, [6:4] the row address, [3:1] the column address, and [0] the polarity (1 = positive).
REQ-016 SHALL accept a packet on a clock edge only when in_valid and in_ready are both high, writing it into the FIFO.
REQ-017 SHALL drive in_ready = (FIFO occupancy < FIFO_DEPTH), derived from registered occupancy only, with no bypass.
REQ-018 SHALL permit simultaneous push and pop in one cycle; occupancy is then unchanged.
REQ-019 SHALL load the output register ("decode") whenever the FIFO is non-empty and (out_valid is low, or out_valid and out_ready are both high).
REQ-020 SHALL have a minimum latency of 2 edges: a packet pushed at edge N appears with out_valid high after edge N+1.
REQ-021 SHALL hold all out_* fields stable while out_valid is high and out_ready is low.
REQ-022 SHALL clear out_valid after a handshake when the FIFO is empty.
REQ-023 SHALL, on decode, set out_group = {row[2],col[2]}, out_lrow = row[1:0] and out_lcol = col[1:0].
REQ-024 SHALL apply the timestamp check on decode: if a prior event exists since reset or frame_clr and the new ts is less than last_ts, set out_ts_err = 1 and increment err_cnt.
REQ-025 SHALL treat an equal timestamp as valid.
REQ-026 SHALL update last_ts on every decode.
REQ-027 SHALL, on decode, increment pos_cnt if pol = 1 and neg_cnt otherwise.
REQ-028 SHALL make all counters saturate at 2^CNT_W-1 with no wrap.
REQ-029 SHALL set active_map[row*8+col] on decode.
REQ-030 SHALL, when frame_clr is high, zero active_map and mark "no prior event"; counters are unaffected.
REQ-031 SHALL, when frame_clr and a decode occur in the same cycle, apply the clear first and then the set: only the new event's bit is 1, and the new event skips the timestamp check and becomes last_ts.
REQ-032 SHALL give the FSM-free datapath a control state of {EMPTY, HOLD}, where HOLD means out_valid = 1.
REQ-033 SHALL transition EMPTY->HOLD on decode, HOLD->EMPTY on handshake with the FIFO empty, and HOLD->HOLD on handshake with the FIFO non-empty (back-to-back, 1 event per cycle).

Reset
REQ-034 SHALL, while reset is low at an edge, flush the FIFO (occupancy 0) and set out_valid = 0, in_ready = 1 on the following cycle, all out_* = 0, out_ts_err = 0, counters = 0, active_map = 0, last_ts = 0, and "no prior event".
REQ-035 SHALL discard an in-flight or buffered packet when reset is asserted mid-operation; no handshake completes in a reset cycle.

Verification
REQ-036 SHALL be verified with single event 0x0000_0010 ts, row 5, col 6, pol 1 -> out_group = 3, out_lrow = 1, out_lcol = 2, pos_cnt = 1, active_map bit 46 set, out_valid 2 edges after push.
REQ-037 SHALL be verified with out_ready held 0 and 5 packets offered -> 4 accepted, in_ready = 0, fifth held; the output stays stable; releasing out_ready drains all 4 back-to-back in order.
REQ-038 SHALL be verified with ts sequence 100, 100, 90, 120 -> out_ts_err = 0, 0, 1, 0 and err_cnt = 1.
REQ-039 SHALL be verified with frame_clr coincident with the decode of an event at row 0, col 0, ts 5 after an event with ts 50 -> active_map = 0x1 and no ts error.
REQ-040 SHALL be verified with pos_cnt preloaded to 0xFFFF via 65535 events then one more positive event -> pos_cnt stays 0xFFFF.
REQ-041 SHALL be verified with reset asserted while 3 packets are buffered -> out_valid = 0, in_ready = 1, all counters 0, and no stale event emitted afterwards.
